dds_sweep_ctrl: RTL



---
 rtl/dds_pkg.sv | 32 +++
 rtl/dds_sweep_dwell_timer.sv | 30 +++
 rtl/dds_sweep_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared DDS types: sweep modes, sweep FSM states and the coarse increment table.
package dds_pkg;

    localparam int ROM_DEPTH     = 16;
    localparam int INC_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        SWEEP_UP       = 2'b00,
        SWEEP_DOWN     = 2'b01,
        SWEEP_PINGPONG = 2'b10
    } sweep_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_e;

    typedef logic [ROM_DEPTH-1:0][INC_WIDTH_DEF-1:0] inc_table_t;

    // Mode 2'b11 has no meaning of its own and sweeps upward.
    function automatic sweep_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'b01:   return SWEEP_DOWN;
            2'b10:   return SWEEP_PINGPONG;
            default: return SWEEP_UP;
        endcase
    endfunction

endpackage

// File: rtl/dds_sweep_dwell_timer.sv
// Loadable dwell down-counter; a zero load behaves as one, expiry is flagged on the last held cycle.
module dds_sweep_dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_load_val,
    input  logic                   i_run,
    output logic                   o_expire
);

    logic [DWELL_WIDTH-1:0] cnt;

    assign o_expire = i_en & i_run & (cnt <= DWELL_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_en) begin
            if (i_load) begin
                cnt <= (i_load_val == '0) ? DWELL_WIDTH'(1) : i_load_val;
            end else if (i_run && cnt > DWELL_WIDTH'(1)) begin
                cnt <= cnt - DWELL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer over the coarse increment table with optional linear fine steps.
// Build option DDS_SWEEP_LOOP_EN: restart from LOAD after each completed sweep until stopped.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | latch config, output first table value
// DWELL    | hold current value for the dwell time
// STEP     | compute and output the next value
// DONE     | pulse done, then IDLE (or LOAD when looping)
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int INC_WIDTH      = 32,
    parameter int DWELL_WIDTH    = 16,
    parameter int MAX_FINE_SHIFT = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_enable,
    input  logic                                i_start,
    input  logic                                i_stop,
    input  logic [1:0]                          i_mode,
    input  logic [3:0]                          i_idx_lo,
    input  logic [3:0]                          i_idx_hi,
    input  logic [2:0]                          i_fine_shift,
    input  logic [DWELL_WIDTH-1:0]              i_dwell,
    input  logic [ROM_DEPTH-1:0][INC_WIDTH-1:0] i_rom_incremento_grueso,
    output logic [INC_WIDTH-1:0]                o_incremento,
    output logic                                o_inc_valid,
    output logic [3:0]                          o_idx,
    output logic                                o_busy,
    output logic                                o_done
);

    sweep_state_e             state;
    sweep_mode_e              mode_q;
    logic [3:0]               lo_q;
    logic [3:0]               hi_q;
    logic [2:0]               shift_q;
    logic [DWELL_WIDTH-1:0]   dwell_q;
    logic                     single_q;
    logic                     dir_up;
    logic [MAX_FINE_SHIFT-1:0] sub;
    logic                     valid_q;
    logic                     done_q;

    sweep_mode_e              ld_mode;
    logic                     ld_single;
    logic [3:0]               ld_idx;
    logic [2:0]               ld_shift;
    logic [3:0]               idx_nb;
    logic [MAX_FINE_SHIFT-1:0] sub_max;
    logic signed [INC_WIDTH:0] diff;
    logic [INC_WIDTH-1:0]     delta;
    logic                     last_val;
    logic                     tmr_expire;
    logic [DWELL_WIDTH-1:0]   tmr_load_val;

    assign ld_mode   = decode_mode(i_mode);
    assign ld_single = (i_idx_lo >= i_idx_hi);
    assign ld_idx    = (ld_mode == SWEEP_DOWN && !ld_single) ? i_idx_hi : i_idx_lo;
    assign ld_shift  = (i_fine_shift > 3'(MAX_FINE_SHIFT)) ? 3'(MAX_FINE_SHIFT) : i_fine_shift;

    // Neighbouring table point in the current direction; delta is the signed per-substep slope.
    assign idx_nb  = dir_up ? o_idx + 4'd1 : o_idx - 4'd1;
    assign sub_max = MAX_FINE_SHIFT'((32'd1 << shift_q) - 32'd1);
    assign diff    = $signed({1'b0, i_rom_incremento_grueso[idx_nb]})
                   - $signed({1'b0, i_rom_incremento_grueso[o_idx]});
    assign delta   = INC_WIDTH'(diff >>> shift_q);

    // Ping-pong flips direction on reaching hi, so its up leg never matches here.
    assign last_val = single_q | ((sub == '0) & (dir_up ? (o_idx == hi_q) : (o_idx == lo_q)));

    assign tmr_load_val = (state == ST_LOAD) ? i_dwell : dwell_q;

    dds_sweep_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_enable),
        .i_load     ((state == ST_LOAD) || (state == ST_STEP)),
        .i_load_val (tmr_load_val),
        .i_run      (state == ST_DWELL),
        .o_expire   (tmr_expire)
    );

    // Pulses stay pending in their registers while disabled and appear once enable returns.
    assign o_inc_valid = valid_q & i_enable;
    assign o_done      = done_q & i_enable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            mode_q       <= SWEEP_UP;
            lo_q         <= '0;
            hi_q         <= '0;
            shift_q      <= '0;
            dwell_q      <= '0;
            single_q     <= 1'b0;
            dir_up       <= 1'b1;
            sub          <= '0;
            o_idx        <= '0;
            o_incremento <= '0;
            o_busy       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else if (i_enable) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_stop && state != ST_IDLE) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start && !i_stop) begin
                            state  <= ST_LOAD;
                            o_busy <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        mode_q       <= ld_mode;
                        lo_q         <= i_idx_lo;
                        hi_q         <= i_idx_hi;
                        shift_q      <= ld_shift;
                        dwell_q      <= i_dwell;
                        single_q     <= ld_single;
                        dir_up       <= (ld_mode != SWEEP_DOWN);
                        sub          <= '0;
                        o_idx        <= ld_idx;
                        o_incremento <= i_rom_incremento_grueso[ld_idx];
                        valid_q      <= 1'b1;
                        state        <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        if (tmr_expire) begin
                            state <= last_val ? ST_DONE : ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        if (sub == sub_max) begin
                            sub          <= '0;
                            o_idx        <= idx_nb;
                            o_incremento <= i_rom_incremento_grueso[idx_nb];
                            if (mode_q == SWEEP_PINGPONG && dir_up && idx_nb == hi_q) begin
                                dir_up <= 1'b0;
                            end
                        end else begin
                            sub          <= sub + 1'b1;
                            o_incremento <= o_incremento + delta;
                        end
                        valid_q <= 1'b1;
                        state   <= ST_DWELL;
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
                        state  <= ST_LOAD;
`else
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
